// File: rtl/usb_rx_pkg.sv
// USB full-speed RX bit decoder: shared types and constants.
// Imported by usb_rx_bit_timer and usb_rx_bit_decoder.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        SE0_1,
        WAIT_EOP
    } rx_state_t;

    localparam int   STUFF_LIMIT = 6;
    localparam logic LEVEL_J     = 1'b1;

endpackage

// File: rtl/usb_rx_bit_timer.sv
// USB RX bit timer: D+ edge detect and mid-bit sample strobe.
// Any edge outside IDLE resynchronises the bit counter.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic idle,
    input  logic start,
    output logic edge_det,
    output logic sample
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          d_plus_prev;
    logic [CW-1:0] cnt;

    assign edge_det = d_plus_sync != d_plus_prev;

    // A resync edge landing on the sample slot suppresses that sample.
    assign sample = !idle && !edge_det && (cnt == HALF);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_plus_prev <= LEVEL_J;
            cnt         <= '0;
        end else begin
            d_plus_prev <= d_plus_sync;
            if (idle && !start)
                cnt <= '0;
            else if (edge_det)
                cnt <= CW'(1);
            else if (cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB FS RX bit front end: NRZI decode, bit unstuffing, EOP detect.
// Define USB_RX_STUFF_CHK_EN to flag a stuff bit that decodes as 1.
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    output logic rx_bit,
    output logic bit_valid,
    output logic eop,
    output logic rx_err,
    output logic rx_active
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LIMIT);

    rx_state_t     state;
    logic          edge_det;
    logic          sample;
    logic          start;
    logic          se0;
    logic          dbit;
    logic          last_level;
    logic          se0_seen;
    logic [OW-1:0] ones;

    assign se0   = !d_plus_sync && !d_minus_sync;
    assign start = (state == IDLE) && edge_det && !d_plus_sync && !se0;
    assign dbit  = d_plus_sync == last_level;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .d_plus_sync(d_plus_sync),
        .idle       (state == IDLE),
        .start      (start),
        .edge_det   (edge_det),
        .sample     (sample)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            rx_bit     <= 1'b0;
            bit_valid  <= 1'b0;
            eop        <= 1'b0;
            rx_err     <= 1'b0;
            rx_active  <= 1'b0;
            last_level <= LEVEL_J;
            se0_seen   <= 1'b0;
            ones       <= '0;
        end else begin
            bit_valid <= 1'b0;
            eop       <= 1'b0;
            rx_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RECEIVE;
                        rx_active <= 1'b1;
                    end
                end
                RECEIVE: begin
                    if (sample && se0) begin
                        state <= SE0_1;
                    end else if (sample) begin
                        last_level <= d_plus_sync;
                        if (ones == STUFF_MAX) begin
                            ones <= '0;
`ifdef USB_RX_STUFF_CHK_EN
                            if (dbit) begin
                                rx_err   <= 1'b1;
                                se0_seen <= 1'b0;
                                state    <= WAIT_EOP;
                            end
`endif
                        end else begin
                            bit_valid <= 1'b1;
                            rx_bit    <= dbit;
                            ones      <= dbit ? ones + 1'b1 : '0;
                        end
                    end
                end
                SE0_1: begin
                    if (sample && se0) begin
                        eop        <= 1'b1;
                        rx_active  <= 1'b0;
                        last_level <= LEVEL_J;
                        ones       <= '0;
                        state      <= IDLE;
                    end else if (sample) begin
                        rx_err     <= 1'b1;
                        last_level <= d_plus_sync;
                        se0_seen   <= 1'b0;
                        state      <= WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    // Only two back-to-back SE0 samples close a broken packet.
                    if (sample && !se0) begin
                        se0_seen   <= 1'b0;
                        last_level <= d_plus_sync;
                    end else if (sample && se0_seen) begin
                        eop        <= 1'b1;
                        rx_active  <= 1'b0;
                        last_level <= LEVEL_J;
                        ones       <= '0;
                        se0_seen   <= 1'b0;
                        state      <= IDLE;
                    end else if (sample) begin
                        se0_seen <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder at 8 clk per bit.
// Honours USB_RX_STUFF_CHK_EN for the stuff-error scenario.
`timescale 1ns/1ps
module tb_usb_rx_bit_decoder;

    localparam int CPB = 8;
    localparam int LJ  = 0;
    localparam int LK  = 1;
    localparam int LS  = 2;

    logic clk = 1'b0;
    logic n_rst;
    logic d_plus_sync;
    logic d_minus_sync;
    logic rx_bit;
    logic bit_valid;
    logic eop;
    logic rx_err;
    logic rx_active;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   excl_viol = 0;
    logic prev_act  = 1'b0;

    int   bv_cyc[$];
    logic bv_val[$];
    int   eop_cyc[$];
    int   err_cyc[$];
    int   rise_cyc[$];
    int   fall_cyc[$];
    int   want_idx[$];
    logic want_val[$];

    usb_rx_bit_decoder #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .d_plus_sync (d_plus_sync),
        .d_minus_sync(d_minus_sync),
        .rx_bit      (rx_bit),
        .bit_valid   (bit_valid),
        .eop         (eop),
        .rx_err      (rx_err),
        .rx_active   (rx_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bit_valid) begin
            bv_cyc.push_back(cyc);
            bv_val.push_back(rx_bit);
        end
        if (eop) eop_cyc.push_back(cyc);
        if (rx_err) err_cyc.push_back(cyc);
        if (rx_active && !prev_act) rise_cyc.push_back(cyc);
        if (!rx_active && prev_act) fall_cyc.push_back(cyc);
        if (int'(bit_valid) + int'(eop) + int'(rx_err) > 1) excl_viol++;
        prev_act = rx_active;
    end

    task automatic check(input string tag, input int obs, input int want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic drive(input int s, input int n);
        case (s)
            LJ:      {d_plus_sync, d_minus_sync} = 2'b10;
            LK:      {d_plus_sync, d_minus_sync} = 2'b01;
            default: {d_plus_sync, d_minus_sync} = 2'b00;
        endcase
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sync();
        drive(LK, CPB); drive(LJ, CPB); drive(LK, CPB); drive(LJ, CPB);
        drive(LK, CPB); drive(LJ, CPB); drive(LK, CPB); drive(LK, CPB);
    endtask

    task automatic start_pkt(output int c0);
        bv_cyc.delete();  bv_val.delete();
        eop_cyc.delete(); err_cyc.delete();
        rise_cyc.delete(); fall_cyc.delete();
        want_idx.delete(); want_val.delete();
        c0 = cyc;
    endtask

    task automatic want_bit(input int idx, input logic v);
        want_idx.push_back(idx);
        want_val.push_back(v);
    endtask

    task automatic want_sync();
        for (int i = 0; i < 7; i++) want_bit(i, 1'b0);
        want_bit(7, 1'b1);
    endtask

    // Bit idx sampled mid-bit; its strobe lands CPB/2+1 after the bit start.
    function automatic int slot(input int idx);
        return CPB / 2 + 1 + CPB * idx;
    endfunction

    task automatic check_packet(input string tag, input int c0,
                                input int eop_idx, input int err_idx);
        int n;
        check($sformatf("%s.bv_count", tag), bv_cyc.size(), want_idx.size());
        n = (bv_cyc.size() < want_idx.size()) ? bv_cyc.size() : want_idx.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.bv%0d_time", tag, i), bv_cyc[i] - c0, slot(want_idx[i]));
            check($sformatf("%s.bv%0d_val", tag, i), int'(bv_val[i]), int'(want_val[i]));
        end
        check($sformatf("%s.eop_count", tag), eop_cyc.size(), int'(eop_idx >= 0));
        if (eop_idx >= 0 && eop_cyc.size() > 0)
            check($sformatf("%s.eop_time", tag), eop_cyc[0] - c0, slot(eop_idx));
        check($sformatf("%s.err_count", tag), err_cyc.size(), int'(err_idx >= 0));
        if (err_idx >= 0 && err_cyc.size() > 0)
            check($sformatf("%s.err_time", tag), err_cyc[0] - c0, slot(err_idx));
        check($sformatf("%s.act_rise_count", tag), rise_cyc.size(), 1);
        if (rise_cyc.size() > 0)
            check($sformatf("%s.act_rise_time", tag), rise_cyc[0] - c0, 1);
        check($sformatf("%s.act_fall_count", tag), fall_cyc.size(), 1);
        if (eop_idx >= 0 && fall_cyc.size() > 0)
            check($sformatf("%s.act_fall_time", tag), fall_cyc[0] - c0, slot(eop_idx));
    endtask

    initial begin
        int c0;
        int packed_bits;

        n_rst = 1'b0;
        drive(LJ, 3);
        check("reset_outputs", int'({rx_bit, bit_valid, eop, rx_err, rx_active}), 0);
        n_rst = 1'b1;
        drive(LJ, 12);
        check("idle_outputs", int'({rx_bit, bit_valid, eop, rx_err, rx_active}), 0);

        // Sync then clean two-bit EOP.
        start_pkt(c0);
        send_sync();
        drive(LS, 2 * CPB);
        drive(LJ, 3 * CPB);
        want_sync();
        check_packet("sync_eop", c0, 9, -1);

        // Six consecutive ones (last sync bit + five) then a stuffed 0.
        start_pkt(c0);
        send_sync();
        repeat (5) drive(LK, CPB);
        drive(LJ, CPB);
        drive(LJ, CPB);
        drive(LK, CPB);
        drive(LS, 2 * CPB);
        drive(LJ, 3 * CPB);
        want_sync();
        for (int i = 8; i <= 12; i++) want_bit(i, 1'b1);
        want_bit(14, 1'b1);
        want_bit(15, 1'b0);
        check_packet("stuff_drop", c0, 17, -1);

        // Seventh consecutive one lands in the stuff slot.
        start_pkt(c0);
        send_sync();
        repeat (7) drive(LK, CPB);
        drive(LJ, CPB);
        drive(LS, 2 * CPB);
        drive(LJ, 3 * CPB);
        want_sync();
        for (int i = 8; i <= 12; i++) want_bit(i, 1'b1);
`ifdef USB_RX_STUFF_CHK_EN
        check_packet("stuff_err", c0, 17, 13);
`else
        want_bit(14, 1'b1);
        want_bit(15, 1'b0);
        check_packet("stuff_err", c0, 17, -1);
`endif

        // One-bit SE0 followed by K is a malformed EOP.
        start_pkt(c0);
        send_sync();
        drive(LJ, CPB);
        drive(LS, CPB);
        drive(LK, CPB);
        drive(LJ, CPB);
        drive(LK, CPB);
        drive(LS, 2 * CPB);
        drive(LJ, 3 * CPB);
        want_sync();
        want_bit(8, 1'b0);
        check_packet("bad_eop", c0, 14, 10);

        // Bit edges jittered by one clock either way.
        start_pkt(c0);
        drive(LK, 7); drive(LJ, 9); drive(LK, 8); drive(LJ, 7);
        drive(LK, 9); drive(LJ, 8); drive(LK, 15);
        drive(LJ, 17);
        drive(LK, 7);
        drive(LS, 17);
        drive(LJ, 20);
        packed_bits = 0;
        foreach (bv_val[i]) packed_bits |= int'(bv_val[i]) << i;
        check("jitter.bv_count", bv_val.size(), 11);
        check("jitter.bits", packed_bits, 640);
        check("jitter.eop_count", eop_cyc.size(), 1);
        check("jitter.err_count", err_cyc.size(), 0);

        // Reset in the middle of a packet.
        start_pkt(c0);
        drive(LK, CPB);
        drive(LJ, CPB);
        drive(LK, 4);
        check("mid_pkt_active", int'(rx_active), 1);
        n_rst = 1'b0;
        {d_plus_sync, d_minus_sync} = 2'b10;
        #1;
        check("mid_pkt_reset_outputs",
              int'({rx_bit, bit_valid, eop, rx_err, rx_active}), 0);
        drive(LJ, 3);
        n_rst = 1'b1;
        drive(LJ, 2 * CPB);
        check("mid_pkt_no_eop", eop_cyc.size(), 0);

        start_pkt(c0);
        send_sync();
        drive(LS, 2 * CPB);
        drive(LJ, 3 * CPB);
        want_sync();
        check_packet("after_reset", c0, 9, -1);

        check("exclusive_pulses", excl_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_decoder.md
# usb_rx_bit_decoder

USB full-speed receive bit-level front end: recovers bit timing from oversampled, already-synchronised D+/D- levels, NRZI-decodes, removes stuffed bits and detects end-of-packet. Sits directly upstream of the CRC-16 checker and the RX byte assembler. rx_bit/bit_valid drive their serial_in/shift_en, and eop/rx_err feed the RX packet controller.

## Interface
- CLKS_PER_BIT, 8: clk cycles per USB bit time; even, ≥4.
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- d_plus_sync  in  1  synchronised D+ level.
- d_minus_sync  in  1  synchronised D- level.
- rx_bit  out  1  decoded, unstuffed data bit; valid only with bit_valid.
- bit_valid  out  1  one-cycle strobe per delivered data bit; drives CRC shift_en.
- eop  out  1  one-cycle pulse on end-of-packet.
- rx_err  out  1  one-cycle pulse on stuff error or malformed EOP.
- rx_active  out  1  high from first K edge until EOP is accepted.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Edge detect: edge = d_plus_sync != d_plus_prev. d_plus_prev resets to 1 (J).
- Bit counter cnt, 0..CLKS_PER_BIT-1.
  - In IDLE, held at 0.
  - Otherwise, on an edge cycle, next cnt = 1.
  - Else increments, wrapping CLKS_PER_BIT-1 → 0.
  - sample = (cnt == CLKS_PER_BIT/2) and state != IDLE.
- Sample classification:
  - SE0 = both inputs 0.
  - Otherwise the level is d_plus_sync.
  - NRZI: bit = 1 if level == last_level, else 0. last_level resets to 1 and updates on every non-SE0 sample.
- Unstuffing: ones counter increments on each decoded 1 and clears on each 0.
  - When ones == 6, the next non-SE0 sample is a stuff bit and is never delivered; ones clears.
  - If that stuff bit decodes as 1, it is a stuff error (see Configuration).
- States:
  - IDLE: a falling d_plus_sync edge while not SE0 sets rx_active and moves to RECEIVE, cnt := 1.
  - RECEIVE: a non-SE0 sample delivers or drops a bit per the unstuffing rule. An SE0 sample moves to SE0_1, with no bit delivered.
  - SE0_1: an SE0 sample pulses eop, clears rx_active, resets last_level/ones and moves to IDLE. A non-SE0 sample pulses rx_err and moves to WAIT_EOP.
  - WAIT_EOP: samples are discarded. Two consecutive SE0 samples pulse eop and go to IDLE, with rx_active cleared.
- bit_valid, eop and rx_err are mutually exclusive in any cycle.

## Timing
- bit_valid/rx_bit, eop and rx_err assert the cycle after the sample cycle.
- First sample comes CLKS_PER_BIT/2 cycles after the edge cycle.
- rx_active rises the cycle after the first K edge. It falls in the same cycle as eop.
- Any edge in any non-IDLE state resynchronises cnt. A resync in the same cycle a sample would occur overrides it, so no sample is taken that cycle.
- Reset mid-packet returns the block to IDLE with counters and last_level at reset values. No eop is generated.

## Configuration
- USB_RX_STUFF_CHK_EN defined: a stuff bit decoding as 1 pulses rx_err (one cycle after the sample) and moves to WAIT_EOP.
- Undefined: the stuff bit is dropped regardless of value, with no rx_err. rx_err then reports only malformed EOPs.

## Structure
- Package usb_rx_pkg holds:
  - state enum (IDLE, RECEIVE, SE0_1, WAIT_EOP)
  - STUFF_LIMIT = 6
  - LEVEL_J = 1'b1
- Sub-module usb_rx_bit_timer contains the edge detect and cnt/sample generation, parameterised by CLKS_PER_BIT.

## Test plan
- Sync field KJKJKJKK at 8 clk/bit → exactly 8 bit_valid strobes, 8 clk apart, with rx_bit = 0,0,0,0,0,0,0,1. rx_active is high after the first K.
- After sync, line unchanged 6 bit times then one transition, then unchanged → six 1s delivered, stuff bit dropped, next delivered bit is 1. There is a 16-clk gap between the 6th and 7th strobes.
- Line unchanged 7 bit times after sync → with the macro, one rx_err pulse and no further bit_valid until EOP. Without the macro, six 1s, no rx_err, and the 8th bit is delivered normally.
- SE0 for 2 bit times then J → single eop pulse, rx_active falls in the same cycle, no bit_valid for SE0 samples.
- SE0 for 1 bit time then K → rx_err pulse. Bits are ignored until a subsequent 2-bit SE0, which yields eop.
- Input edges jittered ±1 clk, plus n_rst asserted mid-packet → jittered case: bits are decoded correctly. Reset case: all outputs are 0 immediately, and the next sync field decodes correctly.
